// File: rtl/scan_sram_loader.sv
// -----------------------------------------------------------------------------
// scan_sram_loader
//   Collects serial scan frames (LANES bits per capture strobe) into a frame
//   register and, when scan enable falls, validates the frame. A valid frame
//   is pushed as {addr,data} into a small write FIFO that drives an SRAM
//   write handshake. A frame whose data and address are all ones ends
//   initialisation: init_done sticks high and all later scan activity is
//   ignored until reset.
//
//   Frame layout, serial order: data LSB-first, address LSB-first, marker (1).
//
// Ports
//   CLK        clock, all state on the rising edge
//   RESET      asynchronous active-high reset
//   scanIn     scan data, bit 0 is the earliest bit of each group
//   SC_STB     one-cycle capture strobe
//   SC_EN      scan enable, a 1->0 transition commits the frame
//   scanOut    frame register LSBs (chain pass-through)
//   wr_valid   FIFO not empty
//   wr_ready   SRAM accepts the head entry
//   wr_addr    head entry address
//   wr_data    head entry data
//   init_done  sticky end-of-init flag
//   frame_err  one-cycle pulse per rejected or dropped frame
//   frame_cnt  saturating count of frames pushed into the FIFO
// -----------------------------------------------------------------------------
module scan_sram_loader #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 8,
    parameter int LANES      = 1,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [LANES-1:0]  scanIn,
    input  logic              SC_STB,
    input  logic              SC_EN,
    output logic [LANES-1:0]  scanOut,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              init_done,
    output logic              frame_err,
    output logic [15:0]       frame_cnt
);

    localparam int FRAME_W = DATA_W + ADDR_W + 1;
    localparam int STROBES = FRAME_W / LANES;
    // Counter saturates above STROBES so over-long frames stay invalid.
    localparam int CNT_W   = $clog2(STROBES + 2);
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W   = $clog2(FIFO_DEPTH + 1);

    if ((FRAME_W % LANES) != 0) begin : g_bad_frame_width
        $error("scan_sram_loader: DATA_W+ADDR_W+1 must be a multiple of LANES");
    end
    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_bad_lanes
        $error("scan_sram_loader: LANES must be 1, 2, 4 or 8");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("scan_sram_loader: FIFO_DEPTH must be a power of two >= 2");
    end

    logic [FRAME_W-1:0]        r_frame;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_en_d;
    logic                      r_init_done;
    logic                      r_err;
    logic [15:0]               r_frame_cnt;
    logic [FRAME_W-2:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]          r_wptr;
    logic [PTR_W-1:0]          r_rptr;
    logic [OCC_W-1:0]          r_occ;

    logic w_shift;
    logic w_commit;
    logic w_good;
    logic w_all_ones;
    logic w_full;
    logic w_pop;
    logic w_push_req;
    logic w_push;

    assign w_shift    = SC_STB & SC_EN & ~r_init_done;
    assign w_commit   = ~SC_EN & r_en_d & ~r_init_done;
    assign w_good     = (r_cnt == CNT_W'(STROBES)) & r_frame[FRAME_W-1];
    assign w_all_ones = &r_frame[FRAME_W-2:0];
    assign w_full     = (r_occ == OCC_W'(FIFO_DEPTH));
    assign w_pop      = wr_valid & wr_ready;
    assign w_push_req = w_commit & w_good & ~w_all_ones;
    // A pop in the commit cycle frees the slot the push needs.
    assign w_push     = w_push_req & (~w_full | w_pop);

    // Frame capture and commit detection
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_frame <= '0;
            r_cnt   <= '0;
            r_en_d  <= 1'b0;
        end else begin
            r_en_d <= SC_EN;
            if (w_shift) begin
                r_frame <= {scanIn, r_frame[FRAME_W-1:LANES]};
                if (r_cnt != '1) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else if (w_commit) begin
                r_cnt <= '0;
            end
        end
    end

    // Commit outcome: error pulse, init flag, accepted-frame counter
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_init_done <= 1'b0;
            r_err       <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_err <= w_commit & (~w_good | (w_push_req & w_full & ~w_pop));
            if (w_commit & w_good & w_all_ones) begin
                r_init_done <= 1'b1;
            end
            if (w_push && r_frame_cnt != 16'hFFFF) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    // Write FIFO
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= r_frame[FRAME_W-2:0];
                r_wptr        <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: ;
            endcase
        end
    end

    assign scanOut   = r_frame[LANES-1:0];
    assign wr_valid  = (r_occ != '0);
    assign wr_data   = r_mem[r_rptr][DATA_W-1:0];
    assign wr_addr   = r_mem[r_rptr][FRAME_W-2:DATA_W];
    assign init_done = r_init_done;
    assign frame_err = r_err;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: doc/scan_sram_loader.md
SCAN_SRAM_LOADER -- requirements
Module: scan_sram_loader

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning SRAM word width.
REQ-002 The block SHALL have parameter ADDR_W, default 8, meaning SRAM address width.
REQ-003 The block SHALL have parameter LANES, default 1 (legal 1/2/4/8), meaning scan bits captured per strobe; elaboration SHALL fail unless (DATA_W+ADDR_W+1) % LANES == 0.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 2 (power of two, >=2), meaning write-buffer entries.
REQ-005 Port: CLK  input  1  sole clock, all state on rising edge.
REQ-006 Port: RESET  input  1  asynchronous, active-high reset.
REQ-007 Port: scanIn  input  LANES  scan data; bit 0 is the earliest bit of each group.
REQ-008 Port: SC_STB  input  1  one-cycle capture strobe, synchronous to CLK.
REQ-009 Port: SC_EN  input  1  scan enable; a 1->0 transition commits a frame.
REQ-010 Port: scanOut  output  LANES  registered frame-register LSBs (chain pass-through).
REQ-011 Port: wr_valid / wr_ready  output / input  1 each  SRAM write handshake.
REQ-012 Port: wr_addr  output  ADDR_W  write address; wr_data  output  DATA_W  write data.
REQ-013 Port: init_done  output  1  sticky end-of-init flag.
REQ-014 Port: frame_err  output  1  one-cycle pulse per rejected frame.
REQ-015 Port: frame_cnt  output  16  saturating count of frames pushed to the FIFO.

Function
REQ-016 Frame SHALL be FRAME_W = DATA_W+ADDR_W+1 bits, serial order: data LSB-first, address LSB-first, marker bit (must be 1).
REQ-017 On SC_STB=1 with SC_EN=1 and init_done=0, frame register SHALL shift right by LANES, scanIn entering at the MSBs; strobe counter SHALL increment, saturating at all-ones.
REQ-018 SC_STB with SC_EN=0 or init_done=1 SHALL be ignored.
REQ-019 Commit SHALL be detected in cycle N where SC_EN=0 and the registered previous SC_EN=1; the counter SHALL clear in cycle N.
REQ-020 At commit: if count*LANES != FRAME_W or marker==0, frame_err SHALL pulse in cycle N+1 and nothing SHALL be written.
REQ-021 At valid commit with data and address both all-ones: init_done SHALL rise in cycle N+1, no write; all later commits and strobes are ignored until reset.
REQ-022 Otherwise {addr,data} SHALL be pushed into the FIFO at the end of cycle N; wr_valid SHALL be high from cycle N+1 when the FIFO was empty (latency 1).
REQ-023 FIFO full at commit with no pop in the same cycle: frame SHALL be dropped and frame_err pulsed; a simultaneous pop SHALL make room (push accepted, occupancy unchanged).
REQ-024 wr_valid SHALL equal FIFO-not-empty; wr_addr/wr_data SHALL present the head entry and stay stable while wr_valid=1 and wr_ready=0; pop SHALL occur on wr_valid&wr_ready.
REQ-025 frame_cnt SHALL increment on each accepted push, saturating at 16'hFFFF.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be tracked with a DEPTH+1-state counter so full and empty are distinguished.
REQ-027 scanOut SHALL equal frame register bits [LANES-1:0], updated the cycle after each shift.

Reset
REQ-028 RESET=1 SHALL asynchronously clear frame register, counter, FIFO, SC_EN history (to 0), init_done, frame_err, frame_cnt, scanOut; wr_valid=0.
REQ-029 Reset mid-frame or with FIFO occupied SHALL discard all partial and buffered data; first SC_EN fall after release SHALL NOT commit unless SC_EN was seen high post-reset.

Verification
REQ-030 Defaults; 41 strobes carrying data 32'h03020100, addr 8'h21, marker 1; SC_EN 1->0, wr_ready=1 -> one-cycle wr_valid with wr_addr=8'h21, wr_data=32'h03020100, frame_cnt=1.
REQ-031 40 strobes then SC_EN fall -> frame_err pulse, no wr_valid, frame_cnt unchanged; same with 41 strobes and marker 0 -> same response.
REQ-032 wr_ready=0, three valid frames (addr 8'h20,8'h21,8'h22) -> first two buffered, third gives frame_err; raising wr_ready yields 8'h20 then 8'h21 in order, outputs stable while stalled.
REQ-033 All-ones frame (41 ones) -> init_done=1, no write; a following valid frame -> ignored, frame_cnt unchanged.
REQ-034 LANES=4, DATA_W=31, ADDR_W=8: 10 strobes per frame, data 31'h12345678, addr 8'h30 -> correct write; 9 strobes -> frame_err.
REQ-035 RESET asserted after 20 strobes, released, then a full 41-strobe frame -> only the post-reset frame written, frame_cnt=1.
